uart_tx: RTL and testbench

Configurable UART transmitter and the transmit-side companion of the UART receiver. It accepts a parallel word over a valid/ready handshake and serialises it onto `o_tx` as start, data (LSB first), optional parity and 1 or 2 stop bits. Bit timing comes from the shared baud generator's `i_uart_clk_enable` strobe. Configuration word layout and clamping are identical to the receiver's, so one config bus can drive both ends.

---
 rtl/uart_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional even parity, 1-2 stops.
// Bit timing from an external baud strobe; config layout shared with uart_rx.
module uart_tx (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_config,
  input  logic [8:0] i_tx_parallel,
  input  logic       i_tx_valid,
  input  logic       i_uart_clk_enable,
  output logic       o_tx,
  output logic       o_ready,
  output logic       o_done
);

  localparam logic [2:0] S_READY  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [8:0] data_q, data_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic [3:0] size_q, size_d;
  logic       pen_q, pen_d;
  logic       nstop_q, nstop_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;

  logic [3:0] cfg_size;
  logic [3:0] size_clamp;
  logic [8:0] mask;
  logic [8:0] masked;
  logic       en;

  assign en       = i_uart_clk_enable;
  assign cfg_size = i_config[4:1];

  always_comb begin
    size_clamp = cfg_size;
    if (cfg_size < 4'd5) size_clamp = 4'd5;
    else if (cfg_size > 4'd9) size_clamp = 4'd9;
  end

  // size_q is always within 5..9, so the shift stays in 0..4
  assign mask   = 9'h1ff >> (4'd9 - size_q);
  assign masked = i_tx_parallel & mask;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    stop_d  = stop_q;
    size_d  = size_q;
    pen_d   = pen_q;
    nstop_d = nstop_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      S_READY: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (i_tx_valid && ready_q) begin
          data_d  = masked;
          par_d   = ^masked;
          ready_d = 1'b0;
          state_d = S_WAIT;
        end else if (i_config[0]) begin
          size_d  = size_clamp;
          pen_d   = i_config[5];
          nstop_d = i_config[6];
        end
      end
      S_WAIT: begin
        if (en) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (en) begin
          tx_d    = data_q[0];
          idx_d   = 4'd1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (en) begin
          if (idx_q == size_q) begin
            if (pen_q) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop_d  = nstop_q;
              state_d = S_STOP;
            end
          end else begin
            tx_d  = data_q[idx_q];
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (en) begin
          tx_d    = 1'b1;
          stop_d  = nstop_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (en) begin
          if (stop_q) begin
            stop_d = 1'b0;
          end else begin
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_READY;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_READY;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_READY;
      idx_q   <= 4'd0;
      data_q  <= 9'd0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      size_q  <= 4'd8;
      pen_q   <= 1'b0;
      nstop_q <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      size_q  <= size_d;
      pen_q   <= pen_d;
      nstop_q <= nstop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected frames are queued at send time and
// compared bit by bit as the line is sampled on each baud strobe.
module tb_uart_tx;

  logic       i_clk;
  logic       i_rst_n;
  logic [6:0] i_config;
  logic [8:0] i_tx_parallel;
  logic       i_tx_valid;
  logic       i_uart_clk_enable;
  logic       o_tx;
  logic       o_ready;
  logic       o_done;

  uart_tx dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_config          (i_config),
    .i_tx_parallel     (i_tx_parallel),
    .i_tx_valid        (i_tx_valid),
    .i_uart_clk_enable (i_uart_clk_enable),
    .o_tx              (o_tx),
    .o_ready           (o_ready),
    .o_done            (o_done)
  );

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  int     checks = 0;
  int     errors = 0;
  int     k = 0;
  bit     in_frame = 0;
  int     gap = 0;
  int     sinced = 0;
  int     done_cnt = 0;
  int     scnt = 0;
  int     m_size = 8;
  bit     m_pe = 0;
  bit     m_two = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [8:0] d, input int sz,
                                input bit pe, input bit two);
    frame_t f;
    logic   p;
    p = 1'b0;
    f.bits = '1;
    f.bits[0] = 1'b0;
    f.n = 1;
    for (int i = 0; i < sz; i++) begin
      f.bits[4'(f.n)] = d[4'(i)];
      p = p ^ d[4'(i)];
      f.n++;
    end
    if (pe) begin
      f.bits[4'(f.n)] = p;
      f.n++;
    end
    f.n += two ? 2 : 1;
    return f;
  endfunction

  // baud strobe: one cycle in four, driven away from the active edge
  initial begin
    i_uart_clk_enable = 1'b0;
    forever begin
      @(negedge i_clk);
      scnt++;
      i_uart_clk_enable = (scnt % 4 == 0);
    end
  end

  // line monitor / scoreboard consumer
  initial begin
    logic en_s, rst_s, prev_tx, prev_done;
    prev_tx = 1'b1;
    prev_done = 1'b0;
    forever begin
      @(posedge i_clk);
      en_s  = i_uart_clk_enable;
      rst_s = i_rst_n;
      #1;
      if (!rst_s) begin
        in_frame = 0;
      end else begin
        if (prev_done) chk("done_pulse", o_done, 1'b0);
        if (o_done) begin
          done_cnt++;
          chk("done_on_strobe", en_s, 1'b1);
          chk("done_in_frame", in_frame, 1'b1);
          chk("done_len", k, cur.n);
          chk("done_ready", o_ready, 1'b1);
          in_frame = 0;
          sinced = 0;
        end else if (en_s) begin
          sinced++;
          if (in_frame) begin
            if (k < cur.n) chk("bit", o_tx, cur.bits[4'(k)]);
            else chk("frame_long", k, cur.n);
            k++;
          end else if (o_tx == 1'b0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_start", 0, 1);
            end else begin
              cur = exp_q.pop_front();
              in_frame = 1;
              gap = sinced;
              k = 1;
            end
          end
        end else begin
          chk("hold", o_tx, prev_tx);
        end
      end
      prev_tx = o_tx;
      prev_done = o_done;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 3000) chk("tmo_ready", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_clk);
    while (!(exp_q.size() == 0 && !in_frame && o_ready) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 3000) chk("tmo_idle", 0, 1);
  endtask

  task automatic wait_k(input int want);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!(in_frame && k >= want) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 3000) chk("tmo_bit", 0, 1);
  endtask

  task automatic cfg(input bit two, input bit pe, input logic [3:0] sz);
    wait_ready();
    i_config = {two, pe, sz, 1'b1};
    @(negedge i_clk);
    i_config = 7'd0;
    m_size = (sz < 5) ? 5 : (sz > 9) ? 9 : int'(sz);
    m_pe = pe;
    m_two = two;
  endtask

  // c is driven alongside valid; a coincident config strobe must be dropped
  task automatic send(input logic [8:0] d, input logic [6:0] c);
    wait_ready();
    i_tx_valid = 1'b1;
    i_tx_parallel = d;
    i_config = c;
    exp_q.push_back(mk(d, m_size, m_pe, m_two));
    @(posedge i_clk);
    #1;
    chk("accept", o_ready, 1'b0);
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    i_config = 7'd0;
    i_tx_parallel = 9'($urandom);
  endtask

  initial begin
    int dc0;
    int n;
    i_rst_n = 1'b0;
    i_config = 7'd0;
    i_tx_parallel = 9'd0;
    i_tx_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      chk("rst_tx", o_tx, 1'b1);
      chk("rst_ready", o_ready, 1'b0);
      chk("rst_done", o_done, 1'b0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rel_ready", o_ready, 1'b1);

    dc0 = done_cnt;
    send(9'h0a5, 7'd0);
    wait_idle();
    chk("8n1_done_cnt", done_cnt - dc0, 1);

    cfg(0, 0, 4'd3);
    send(9'h1ff, 7'd0);
    wait_idle();
    cfg(0, 0, 4'd15);
    send(9'h155, 7'd0);
    wait_idle();

    cfg(1, 1, 4'd8);
    send(9'h007, 7'd0);
    wait_idle();
    cfg(1, 1, 4'd9);
    send(9'h1a5, 7'd0);
    wait_idle();

    cfg(0, 0, 4'd8);
    send(9'h03c, 7'd0);
    wait_k(4);
    i_config = 7'b0_0_0101_1;
    @(negedge i_clk);
    i_config = 7'd0;
    wait_idle();
    send(9'h03c, 7'd0);
    wait_idle();
    cfg(0, 0, 4'd5);
    send(9'h01e, 7'd0);
    wait_idle();

    cfg(0, 0, 4'd8);
    wait_ready();
    i_tx_valid = 1'b1;
    i_tx_parallel = 9'h055;
    exp_q.push_back(mk(9'h055, m_size, m_pe, m_two));
    @(posedge i_clk);
    #1;
    chk("b2b_accept1", o_ready, 1'b0);
    @(negedge i_clk);
    i_tx_parallel = 9'h00f;
    exp_q.push_back(mk(9'h00f, m_size, m_pe, m_two));
    n = 0;
    @(posedge i_clk);
    #1;
    while (!o_done && n < 3000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("tmo_done", 0, 1);
    @(posedge i_clk);
    #1;
    chk("b2b_accept2", o_ready, 1'b0);
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    wait_idle();
    chk("b2b_gap", gap, 1);

    send(9'h0ab, 7'b1_1_0110_1);
    wait_idle();
    send(9'h0ab, 7'd0);
    wait_idle();

    cfg(0, 0, 4'd5);
    m_size = 8;
    cfg(0, 0, 4'd8);
    send(9'h0b3, 7'd0);
    wait_k(5);
    dc0 = done_cnt;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    chk("mid_rst_tx", o_tx, 1'b1);
    chk("mid_rst_ready", o_ready, 1'b0);
    repeat (3) begin
      @(posedge i_clk);
      #1;
      chk("mid_rst_done", o_done, 1'b0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_size = 8;
    m_pe = 0;
    m_two = 0;
    @(posedge i_clk);
    #1;
    chk("mid_rel_ready", o_ready, 1'b1);
    chk("mid_no_done", done_cnt - dc0, 0);
    send(9'h0a5, 7'd0);
    wait_idle();
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
